// File: rtl/xy_dac_mux.sv
// Time-multiplexes one X/Y coordinate pair onto a shared DAC bus and issues
// per-channel latch strobes after a settle time; blanking follows the Y latch.
module xy_dac_mux #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_blank,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_sel,
    output logic              dac_wr_x,
    output logic              dac_wr_y,
    output logic              blank_out,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        X_SETUP,
        X_STROBE,
        Y_SETUP,
        Y_STROBE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] x_q, y_q, x_nxt, y_nxt;
    logic              blank_q, blank_nxt;
    logic              accept;

    logic [DATA_W-1:0] data_nxt;
    logic              sel_nxt, wr_x_nxt, wr_y_nxt, blank_out_nxt;

    // in_ready is the registered view of IDLE, so it also suppresses an
    // accept in the first cycle after reset
    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = x_q;
        y_nxt     = y_q;
        blank_nxt = blank_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    x_nxt     = in_x;
                    y_nxt     = in_y;
                    blank_nxt = in_blank;
                    state_nxt = X_SETUP;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            X_SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = X_STROBE;
                    cnt_nxt   = STROBE_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            X_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = Y_SETUP;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            Y_SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = Y_STROBE;
                    cnt_nxt   = STROBE_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            Y_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port is a flop
    always_comb begin
        data_nxt      = dac_data;
        sel_nxt       = dac_sel;
        wr_x_nxt      = 1'b0;
        wr_y_nxt      = 1'b0;
        blank_out_nxt = blank_out;
        case (state_nxt)
            X_SETUP: begin
                data_nxt = x_nxt;
                sel_nxt  = 1'b0;
            end
            X_STROBE: begin
                data_nxt = x_nxt;
                sel_nxt  = 1'b0;
                wr_x_nxt = 1'b1;
            end
            Y_SETUP: begin
                data_nxt = y_nxt;
                sel_nxt  = 1'b1;
            end
            Y_STROBE: begin
                data_nxt = y_nxt;
                sel_nxt  = 1'b1;
                wr_y_nxt = 1'b1;
                if (state != Y_STROBE) begin
                    blank_out_nxt = blank_nxt;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        x_q     <= x_nxt;
        y_q     <= y_nxt;
        blank_q <= blank_nxt;
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            dac_data  <= '0;
            dac_sel   <= 1'b0;
            dac_wr_x  <= 1'b0;
            dac_wr_y  <= 1'b0;
            blank_out <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dac_data  <= data_nxt;
            dac_sel   <= sel_nxt;
            dac_wr_x  <= wr_x_nxt;
            dac_wr_y  <= wr_y_nxt;
            blank_out <= blank_out_nxt;
            busy      <= (state_nxt != IDLE);
            in_ready  <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_xy_dac_mux.sv
// Directed bench for xy_dac_mux: default instance plus a SETTLE=1/STROBE=3 instance.
module tb_xy_dac_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x1, y1, x2, y2;
    logic       b1, b2, v1, v2;
    logic       rdy1, rdy2, sel1, sel2, wrx1, wrx2, wry1, wry2, bo1, bo2, busy1, busy2;
    logic [7:0] d1, d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xy_dac_mux dut1 (
        .clk(clk), .reset(reset), .in_x(x1), .in_y(y1), .in_blank(b1), .in_valid(v1),
        .in_ready(rdy1), .dac_data(d1), .dac_sel(sel1), .dac_wr_x(wrx1), .dac_wr_y(wry1),
        .blank_out(bo1), .busy(busy1)
    );

    xy_dac_mux #(.DATA_W(8), .SETTLE_CYCLES(1), .STROBE_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .in_x(x2), .in_y(y2), .in_blank(b2), .in_valid(v2),
        .in_ready(rdy2), .dac_data(d2), .dac_sel(sel2), .dac_wr_x(wrx2), .dac_wr_y(wry2),
        .blank_out(bo2), .busy(busy2)
    );

    // exp = {data[7:0], sel, wr_x, wr_y, blank_out, busy, in_ready}
    typedef struct {
        logic        rst;
        logic        valid;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        blank;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic valid, input logic [7:0] x,
                                input logic [7:0] y, input logic blank, input logic [7:0] data,
                                input logic sel, input logic wrx, input logic wry,
                                input logic bo, input logic bsy, input logic rdy);
        vec_t v;
        v.rst   = rst;
        v.valid = valid;
        v.x     = x;
        v.y     = y;
        v.blank = blank;
        v.exp   = {data, sel, wrx, wry, bo, bsy, rdy};
        return v;
    endfunction

    task automatic run_row(input vec_t v, input bit second, input int idx);
        logic [13:0] got;
        reset = v.rst;
        if (second) begin
            v2 = v.valid; x2 = v.x; y2 = v.y; b2 = v.blank;
        end else begin
            v1 = v.valid; x1 = v.x; y1 = v.y; b1 = v.blank;
        end
        @(posedge clk);
        #1;
        got = second ? {d2, sel2, wrx2, wry2, bo2, busy2, rdy2}
                     : {d1, sel1, wrx1, wry1, bo1, busy1, rdy1};
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s row %0d: got {data,sel,wrx,wry,blank,busy,rdy}=%h/%b required %h/%b",
                     second ? "dut2" : "dut1", idx, got[13:6], got[5:0], v.exp[13:6], v.exp[5:0]);
        end
    endtask

    vec_t tbl1[$];
    vec_t tbl2[$];

    initial begin
        int idx, nx, ny;
        int acc_cyc[3];
        bit acc;

        reset = 1'b1;
        v1 = 0; x1 = 0; y1 = 0; b1 = 0;
        v2 = 0; x2 = 0; y2 = 0; b2 = 0;

        // reset held 3 cycles, then release
        for (int i = 0; i < 3; i++) tbl1.push_back(mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 1));
        // single unblanked point 0x12/0xAB
        tbl1.push_back(mk(0, 1, 8'h12, 8'hAB, 0, 8'h12, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h12, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h12, 0, 1, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hAB, 1, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hAB, 1, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hAB, 1, 0, 1, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hAB, 1, 0, 0, 0, 0, 1));
        // blanked point: blank_out stays 0 until Y_STROBE entry
        tbl1.push_back(mk(0, 1, 8'hFF, 8'h00, 1, 8'hFF, 0, 0, 0, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 0, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 1, 0, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 1));
        // reset during the X strobe discards the point
        tbl1.push_back(mk(0, 1, 8'h34, 8'h56, 0, 8'h34, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h34, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h34, 0, 1, 0, 1, 1, 0));
        tbl1.push_back(mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        tbl1.push_back(mk(0, 1, 8'h34, 8'h56, 0, 8'h00, 0, 0, 0, 1, 0, 1));
        tbl1.push_back(mk(0, 1, 8'h34, 8'h56, 0, 8'h34, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h34, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h34, 0, 1, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h56, 1, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h56, 1, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h56, 1, 0, 1, 0, 1, 0));
        tbl1.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h56, 1, 0, 0, 0, 0, 1));

        // SETTLE=1, STROBE=3: 9-cycle period
        tbl2.push_back(mk(0, 1, 8'h3C, 8'hC3, 0, 8'h3C, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl2.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h3C, 0, 1, 0, 1, 1, 0));
        tbl2.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hC3, 1, 0, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl2.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hC3, 1, 0, 1, 0, 1, 0));
        tbl2.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hC3, 1, 0, 0, 0, 0, 1));
        tbl2.push_back(mk(0, 1, 8'h11, 8'h22, 1, 8'h11, 0, 0, 0, 0, 1, 0));

        for (int i = 0; i < tbl1.size(); i++) run_row(tbl1[i], 1'b0, i);

        // streaming: in_valid held high for three points
        idx = 0; nx = 0; ny = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            v1 = (idx < 3);
            x1 = 8'(idx);
            y1 = 8'(8'h80 + idx);
            b1 = 1'b0;
            acc = rdy1 && v1;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (wrx1 && wry1) begin
                checks++; errors++;
                $display("FAIL both_strobes cycle %0d: wr_x=%b wr_y=%b required not both 1", cyc, wrx1, wry1);
            end
            if (wrx1) begin
                nx++;
                checks++;
                if (d1 !== 8'(idx - 1) || sel1 !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_x cycle %0d: data=%h sel=%b required %h/0", cyc, d1, sel1, 8'(idx - 1));
                end
            end
            if (wry1) begin
                ny++;
                checks++;
                if (d1 !== 8'(8'h80 + idx - 1) || sel1 !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_y cycle %0d: data=%h sel=%b required %h/1", cyc, d1, sel1, 8'(8'h80 + idx - 1));
                end
            end
        end
        v1 = 1'b0;
        checks++;
        if (idx != 3 || nx != 3 || ny != 3) begin
            errors++;
            $display("FAIL stream_counts: accepts=%0d xstrobes=%0d ystrobes=%0d required 3/3/3", idx, nx, ny);
        end
        checks++;
        if (idx == 3 && (acc_cyc[1] - acc_cyc[0] != 7 || acc_cyc[2] - acc_cyc[1] != 7)) begin
            errors++;
            $display("FAIL stream_period: spacing %0d,%0d required 7,7",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end

        for (int i = 0; i < tbl2.size(); i++) run_row(tbl2[i], 1'b1, i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xy_dac_mux.md
Name: xy_dac_mux

Overview:
Output stage that sits directly downstream of the X/Y wave generators in the vector-display path. It accepts one X/Y coordinate pair per handshake. It time-multiplexes the pair onto a single 8-bit output bus that drives two external latching DACs (X latch, Y latch). It also generates per-channel write strobes after a programmable settle time, and updates the beam blanking output once both coordinates are latched.

Parameters:
DATA_W, 8, width of each coordinate and of the output bus
SETTLE_CYCLES, 2, cycles the bus is held stable before the write strobe asserts; legal range 1..15
STROBE_CYCLES, 1, width of each write strobe in cycles; legal range 1..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_x  input  DATA_W  X coordinate from the upstream generator
in_y  input  DATA_W  Y coordinate from the upstream generator
in_blank  input  1  1 = beam off for this point
in_valid  input  1  upstream has a point
in_ready  output  1  block can accept a point this cycle
dac_data  output  DATA_W  shared bus to both external DAC latches
dac_sel  output  1  0 = bus carries X, 1 = bus carries Y
dac_wr_x  output  1  write strobe, X latch
dac_wr_y  output  1  write strobe, Y latch
blank_out  output  1  beam blanking, 1 = off
busy  output  1  sample in flight (not IDLE)

Behaviour:
- Reset is synchronous and active-high on clk. All outputs are registered.
- Reset values: dac_data=0, dac_sel=0, dac_wr_x=0, dac_wr_y=0, blank_out=1, busy=0, in_ready=0. The state goes to IDLE.
- in_ready is 1 in IDLE when reset is not asserted. It is 0 in every other state and during reset.
- Accept condition: the sampling edge has in_valid=1 and in_ready=1 (IDLE). On that edge:
  - in_x, in_y and in_blank are captured into internal registers.
  - The state goes to X_SETUP.
  - in_valid while in_ready=0 is ignored; upstream holds its data.
- FSM states: IDLE, X_SETUP, X_STROBE, Y_SETUP, Y_STROBE. A 4-bit down-counter times the SETUP and STROBE phases.
- X_SETUP: dac_data=captured x, dac_sel=0, strobes 0. Lasts SETTLE_CYCLES cycles, then goes to X_STROBE.
- X_STROBE: dac_data=x, dac_sel=0, dac_wr_x=1. Lasts STROBE_CYCLES cycles, then goes to Y_SETUP.
- Y_SETUP: dac_data=captured y, dac_sel=1, strobes 0. Lasts SETTLE_CYCLES cycles, then goes to Y_STROBE.
- Y_STROBE: dac_data=y, dac_sel=1, dac_wr_y=1. Lasts STROBE_CYCLES cycles, then goes to IDLE.
- blank_out loads the captured blank on the edge that enters Y_STROBE. It holds that value until the next entry into Y_STROBE or until reset.
- IDLE: dac_data and dac_sel hold their last values (y, 1 after the first sample). Strobes are 0.
- IDLE lasts at least 1 cycle. Point period = 2*(SETTLE_CYCLES+STROBE_CYCLES)+1 cycles, which is 7 with defaults.
- busy = 1 in every state except IDLE.
- dac_wr_x and dac_wr_y are never both 1 in the same cycle.
- The strobe-to-bus relationship is fixed: dac_data and dac_sel do not change in any cycle where a strobe is 1, or in the cycle immediately before a strobe asserts.
- Reset mid-operation:
  - The next edge applies the reset values.
  - The in-flight point is discarded, and no further strobe is issued for it.
  - blank_out returns to 1.
- The counter never wraps. Counter loads are SETTLE_CYCLES-1 and STROBE_CYCLES-1, and a phase ends when the counter reaches 0.

Test Plan:
- Reset held 3 cycles, then released -> during reset dac_data=0, blank_out=1, in_ready=0; first cycle after release in_ready=1, busy=0.
- Single point x=0x12, y=0xAB, blank=0, accepted at edge E0 (defaults), cycles counted after each edge:
  - X phase: after E0–E1 dac_data=0x12, sel=0; after E2 dac_wr_x=1.
  - Y phase: after E3–E4 dac_data=0xAB, sel=1; after E5 dac_wr_y=1 and blank_out=0.
  - Return: after E6 in_ready=1 again.
- in_valid held high with points (0x00,0x80), (0x01,0x81), (0x02,0x82) -> accepts exactly every 7 cycles; 3 X strobes and 3 Y strobes, each strobe with the matching bus value.
- Blanked point (x=0xFF, y=0x00, blank=1) after an unblanked point -> blank_out stays 0 until the edge entering Y_STROBE of the blanked point, then goes 1.
- reset asserted in the cycle dac_wr_x=1 -> next cycle all outputs are at reset values; no dac_wr_y pulse follows; the next accepted point runs a full normal sequence.
- Instance with SETTLE_CYCLES=1, STROBE_CYCLES=3 -> X setup 1 cycle, dac_wr_x high 3 consecutive cycles, period 9 cycles; dac_data stable across each strobe.
